// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: one-outstanding word fetch into a DEPTH-entry {inst,pc} queue; IF_PREFETCH_PERF_EN adds perf counters.
// Latency: request 1 cycle after a slot is known free; instruction on inst 1 cycle after mem_ack.
// Backpressure: inst_ready low fills the queue; no request is issued unless its response is sure to fit.

module if_pfq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 96
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    always_ff @(posedge CLK) begin
        if (reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rptr];
    assign o_count    = r_count;
endmodule

module if_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic [PC_W-1:0]        startpc,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   mem_req,
    output logic [PC_W-1:0]        mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst,
    output logic [PC_W-1:0]        inst_pc,
`ifdef IF_PREFETCH_PERF_EN
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_flushed,
`endif
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
    } entry_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] w_fetch_pc_nxt;
    logic [PC_W-1:0] r_addr;
    logic [PC_W-1:0] w_addr_nxt;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_nxt;
    entry_t          w_push_dat;
    entry_t          w_head;

    // Redirect wins over a coincident ack, so that response never enters the queue.
    assign w_push      = (r_state == REQ) & mem_ack & ~redirect;
    assign w_pop       = inst_valid & inst_ready;
    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
    assign w_push_dat  = '{inst: mem_rdata, pc: r_addr};

    if_pfq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .CLK        (CLK),
        .reset      (reset),
        .i_flush    (redirect),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= startpc;
            r_addr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_addr     <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_addr_nxt     = r_addr;
        unique case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                end else if (w_count_nxt < FULL) begin
                    w_state_nxt = REQ;
                    w_addr_nxt  = r_fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                    w_state_nxt    = mem_ack ? IDLE : DROP;
                end else if (mem_ack) begin
                    w_fetch_pc_nxt = r_fetch_pc + PC_W'(4);
                    if (w_count_nxt < FULL) begin
                        w_addr_nxt = r_fetch_pc + PC_W'(4);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                // Stale address stays on the bus until memory answers it.
                if (redirect) w_fetch_pc_nxt = redirect_pc;
                if (mem_ack)  w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem_req    = (r_state != IDLE);
    assign mem_addr   = r_addr;
    assign count      = w_count;
    assign inst_valid = (w_count != '0);
    assign inst       = inst_valid ? w_head.inst : '0;
    assign inst_pc    = inst_valid ? w_head.pc : '0;

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0]   r_perf_fetched;
    logic [31:0]   r_perf_flushed;
    logic [CW-1:0] w_flush_cnt;
    logic [32:0]   w_fetched_sum;
    logic [32:0]   w_flushed_sum;

    // A request still in REQ is counted once here; its later ack in DROP is not recounted.
    assign w_flush_cnt   = w_count - CW'(w_pop) + CW'(r_state == REQ);
    assign w_fetched_sum = {1'b0, r_perf_fetched} + 33'(w_pop);
    assign w_flushed_sum = {1'b0, r_perf_flushed} + 33'(w_flush_cnt);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            r_perf_fetched <= w_fetched_sum[32] ? '1 : w_fetched_sum[31:0];
            if (redirect) r_perf_flushed <= w_flushed_sum[32] ? '1 : w_flushed_sum[31:0];
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed scenarios plus a randomized run against a queue-level reference model.
module tb_if_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            CLK = 1'b0;
    logic            reset = 1'b1;
    logic [PC_W-1:0] startpc = 64'h1000;
    logic            redirect = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            mem_req;
    logic [PC_W-1:0] mem_addr;
    logic            mem_ack;
    logic [31:0]     mem_rdata;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic [CW-1:0]   count;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_flushed;
`endif

    logic ack_en = 1'b0;
    logic stray_ack = 1'b0;
    int   lat = 0;
    int   r_wait = 0;
    int   checks = 0;
    int   errors = 0;

    if_prefetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .startpc     (startpc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
`ifdef IF_PREFETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
`endif
        .count       (count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [PC_W-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    // Memory: answers a held request once it has waited lat cycles.
    assign mem_rdata = word_of(mem_addr);
    assign mem_ack   = stray_ack | (ack_en & mem_req & (r_wait >= lat));
    always @(posedge CLK) r_wait <= (!mem_req || mem_ack) ? 0 : r_wait + 1;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset(input logic [PC_W-1:0] pc);
        startpc   = pc;
        redirect  = 1'b0;
        stray_ack = 1'b0;
        reset     = 1'b1;
        next_cycle();
        next_cycle();
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        startpc = 64'h1000;
        next_cycle();
        next_cycle();
        checks++;
        if (count !== '0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL reset_queue: count=%0d valid=%b required count=0 valid=0", count, inst_valid);
        end
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: mem_req=%b required 0", mem_req);
        end
        checks++;
        if (inst !== '0 || inst_pc !== '0) begin
            errors++; $display("FAIL reset_head: inst=%h pc=%h required 0/0", inst, inst_pc);
        end
    endtask

    task automatic test_zero_wait();
        ack_en = 1'b1; lat = 0; inst_ready = 1'b1;
        apply_reset(64'h1000);
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL zw_idle: mem_req=%b required 0", mem_req);
        end
        next_cycle(); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin
            errors++; $display("FAIL zw_first_req: req=%b addr=%h required 1/1000", mem_req, mem_addr);
        end
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            logic [PC_W-1:0] exp_pc;
            exp_pc = 64'h1000 + PC_W'(4 * i);
            #1;
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== word_of(exp_pc)) begin
                errors++; $display("FAIL zw_stream[%0d]: valid=%b pc=%h inst=%h required 1/%h/%h",
                                   i, inst_valid, inst_pc, inst, exp_pc, word_of(exp_pc));
            end
            next_cycle();
        end
    endtask

    task automatic test_full_stall();
        int acks;
        ack_en = 1'b1; lat = 0; inst_ready = 1'b0;
        apply_reset(64'h1000);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_req && mem_ack) begin
                checks++;
                if (mem_addr !== 64'h1000 + PC_W'(4 * acks)) begin
                    errors++; $display("FAIL stall_addr[%0d]: addr=%h required %h", acks, mem_addr, 64'h1000 + PC_W'(4 * acks));
                end
                acks++;
            end
            next_cycle();
        end
        #1;
        checks++;
        if (acks != DEPTH || count !== CW'(DEPTH) || mem_req !== 1'b0) begin
            errors++; $display("FAIL stall_full: acks=%0d count=%0d req=%b required %0d/%0d/0", acks, count, mem_req, DEPTH, DEPTH);
        end
        checks++;
        if (inst_pc !== 64'h1000) begin
            errors++; $display("FAIL stall_head: pc=%h required 1000", inst_pc);
        end
        inst_ready = 1'b1;
        next_cycle(); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h1010 || count !== CW'(3)) begin
            errors++; $display("FAIL stall_resume: req=%b addr=%h count=%0d required 1/1010/3", mem_req, mem_addr, count);
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_drop();
        int guard;
        ack_en = 1'b1; lat = 3; inst_ready = 1'b1;
        apply_reset(64'h1000);
        next_cycle();
        redirect = 1'b1; redirect_pc = 64'h2000;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h1000 || mem_ack !== 1'b0) begin
            errors++; $display("FAIL drop_pending: req=%b addr=%h ack=%b required 1/1000/0", mem_req, mem_addr, mem_ack);
        end
        next_cycle();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 64'h1000 || count !== '0) begin
                errors++; $display("FAIL drop_hold[%0d]: req=%b addr=%h count=%0d required 1/1000/0", k, mem_req, mem_addr, count);
            end
            if (k == 2) begin
                checks++;
                if (mem_ack !== 1'b1) begin
                    errors++; $display("FAIL drop_ack: ack=%b required 1", mem_ack);
                end
            end
            next_cycle();
        end
        #1;
        checks++;
        if (mem_req !== 1'b0 || count !== '0) begin
            errors++; $display("FAIL drop_idle: req=%b count=%0d required 0/0", mem_req, count);
        end
        next_cycle(); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h2000) begin
            errors++; $display("FAIL drop_newreq: req=%b addr=%h required 1/2000", mem_req, mem_addr);
        end
        guard = 0;
        while (!inst_valid && guard < 20) begin
            next_cycle(); #1;
            guard++;
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h2000 || inst !== word_of(64'h2000)) begin
            errors++; $display("FAIL drop_first_inst: valid=%b pc=%h inst=%h required 1/2000/%h", inst_valid, inst_pc, inst, word_of(64'h2000));
        end
    endtask

    task automatic test_redirect_ack_pop();
        int guard;
        ack_en = 1'b1; lat = 0; inst_ready = 1'b0;
        apply_reset(64'h1000);
        guard = 0;
        #1;
        while (count !== CW'(2) && guard < 20) begin
            next_cycle(); #1;
            guard++;
        end
        redirect = 1'b1; redirect_pc = 64'h3000; inst_ready = 1'b1;
        #1;
        checks++;
        if (count !== CW'(2) || mem_ack !== 1'b1 || mem_addr !== 64'h1008) begin
            errors++; $display("FAIL rap_setup: count=%0d ack=%b addr=%h required 2/1/1008", count, mem_ack, mem_addr);
        end
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h1000 || inst !== word_of(64'h1000)) begin
            errors++; $display("FAIL rap_popped: valid=%b pc=%h inst=%h required 1/1000/%h", inst_valid, inst_pc, inst, word_of(64'h1000));
        end
        next_cycle();
        redirect = 1'b0; inst_ready = 1'b0;
        #1;
        checks++;
        if (count !== '0 || inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rap_flushed: count=%0d valid=%b req=%b required 0/0/0", count, inst_valid, mem_req);
        end
        next_cycle(); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h3000) begin
            errors++; $display("FAIL rap_newreq: req=%b addr=%h required 1/3000", mem_req, mem_addr);
        end
        next_cycle(); #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h3000 || count !== CW'(1)) begin
            errors++; $display("FAIL rap_first_inst: valid=%b pc=%h count=%0d required 1/3000/1", inst_valid, inst_pc, count);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        ack_en = 1'b1; lat = 0; inst_ready = 1'b0;
        apply_reset(64'h1000);
        guard = 0;
        #1;
        while (count !== CW'(3) && guard < 20) begin
            next_cycle(); #1;
            guard++;
        end
        ack_en = 1'b0; reset = 1'b1;
        #1;
        checks++;
        if (count !== CW'(3) || mem_req !== 1'b1 || mem_ack !== 1'b0) begin
            errors++; $display("FAIL rmid_setup: count=%0d req=%b ack=%b required 3/1/0", count, mem_req, mem_ack);
        end
        next_cycle();
        reset = 1'b0; stray_ack = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || count !== '0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_cleared: req=%b count=%0d valid=%b required 0/0/0", mem_req, count, inst_valid);
        end
        next_cycle();
        stray_ack = 1'b0;
        #1;
        checks++;
        if (count !== '0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_stray: count=%0d valid=%b required 0/0", count, inst_valid);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h1000) begin
            errors++; $display("FAIL rmid_restart: req=%b addr=%h required 1/1000", mem_req, mem_addr);
        end
    endtask

    task automatic test_random();
        logic [PC_W-1:0] q[$];
        logic [PC_W-1:0] next_fetch;
        logic [PC_W-1:0] prev_addr;
        logic [CW-1:0]   exp_cnt;
        logic            stale, prev_pend, req, ack, pop, rd;
        int              pops;
        ack_en = 1'b1; lat = 0; inst_ready = 1'b0;
        apply_reset({$urandom, $urandom});
        q = {};
        next_fetch = startpc;
        stale = 1'b0; prev_pend = 1'b0; prev_addr = '0; pops = 0;
        for (int i = 0; i < 3000; i++) begin
            inst_ready  = ($urandom_range(0, 99) < ((((i / 200) % 2) == 1) ? 25 : 85));
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? {32'hFFFF_FFFF, 32'hFFFF_FFF0 | ($urandom & 32'hF)}
                                                       : {$urandom, $urandom};
            lat = $urandom_range(0, 3);
            #1;
            req = mem_req; ack = mem_req & mem_ack; pop = inst_valid & inst_ready; rd = redirect;
            exp_cnt = CW'(q.size());
            checks++;
            if (count !== exp_cnt) begin
                errors++; $display("FAIL rnd_count@%0d: count=%0d required %0d", i, count, exp_cnt);
            end
            checks++;
            if (q.size() != 0) begin
                if (inst_valid !== 1'b1 || inst_pc !== q[0] || inst !== word_of(q[0])) begin
                    errors++; $display("FAIL rnd_head@%0d: valid=%b pc=%h inst=%h required 1/%h/%h", i, inst_valid, inst_pc, inst, q[0], word_of(q[0]));
                end
            end else if (inst_valid !== 1'b0 || inst !== '0 || inst_pc !== '0) begin
                errors++; $display("FAIL rnd_empty@%0d: valid=%b pc=%h inst=%h required 0/0/0", i, inst_valid, inst_pc, inst);
            end
            if (req && !stale) begin
                checks++;
                if (mem_addr !== next_fetch) begin
                    errors++; $display("FAIL rnd_addr@%0d: addr=%h required %h", i, mem_addr, next_fetch);
                end
            end
            if (prev_pend) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
                    errors++; $display("FAIL rnd_hold@%0d: req=%b addr=%h required 1/%h", i, mem_req, mem_addr, prev_addr);
                end
            end
            prev_pend = req && !ack;
            prev_addr = mem_addr;
            if (pop && q.size() != 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (rd) begin
                q = {};
                next_fetch = redirect_pc;
                stale = req && !ack;
            end else if (ack) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    q.push_back(mem_addr);
                    next_fetch = next_fetch + PC_W'(4);
                end
            end
            next_cycle();
        end
        redirect = 1'b0;
        checks++;
        if (pops < 200) begin
            errors++; $display("FAIL rnd_progress: pops=%0d required at least 200", pops);
        end
    endtask

`ifdef IF_PREFETCH_PERF_EN
    task automatic test_perf();
        int pops;
        int guard;
        ack_en = 1'b1; lat = 0; inst_ready = 1'b1;
        apply_reset(64'h4000);
        #1;
        checks++;
        if (perf_fetched !== '0 || perf_flushed !== '0) begin
            errors++; $display("FAIL perf_reset: fetched=%0d flushed=%0d required 0/0", perf_fetched, perf_flushed);
        end
        pops = 0; guard = 0;
        while (pops < 10 && guard < 100) begin
            if (inst_valid && inst_ready) pops++;
            guard++;
            next_cycle(); #1;
        end
        inst_ready = 1'b0;
        guard = 0;
        while (count !== CW'(2) && guard < 20) begin
            next_cycle(); #1;
            guard++;
        end
        ack_en = 1'b0; redirect = 1'b1; redirect_pc = 64'h5000;
        #1;
        checks++;
        if (count !== CW'(2) || mem_req !== 1'b1 || mem_ack !== 1'b0) begin
            errors++; $display("FAIL perf_setup: count=%0d req=%b ack=%b required 2/1/0", count, mem_req, mem_ack);
        end
        next_cycle();
        redirect = 1'b0;
        #1;
        checks++;
        if (perf_fetched !== 32'd10 || perf_flushed !== 32'd3) begin
            errors++; $display("FAIL perf_counts: fetched=%0d flushed=%0d required 10/3", perf_fetched, perf_flushed);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_full_stall();
        test_redirect_drop();
        test_redirect_ack_pop();
        test_reset_mid();
        test_random();
`ifdef IF_PREFETCH_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end directly upstream of the processor datapath.
- Issues word fetches to instruction memory over a variable-latency req/ack interface.
- Buffers returned instructions with their PCs in a small FIFO and presents them to the datapath with a valid/ready handshake.
- Supports a redirect (taken branch) that flushes the queue and discards any in-flight fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- PC_W, 64, PC/address width.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- startpc  input  PC_W  PC loaded into the fetch pointer on reset
- redirect  input  1  flush queue, restart fetch at redirect_pc
- redirect_pc  input  PC_W  new fetch address
- mem_req  output  1  fetch request to instruction memory
- mem_addr  output  PC_W  fetch address; stable while mem_req=1
- mem_ack  input  1  memory returns data this cycle; meaningful only while mem_req=1
- mem_rdata  input  32  instruction word, valid when mem_ack=1
- inst_valid  output  1  queue head is valid
- inst_ready  input  1  datapath consumes head this cycle
- inst  output  32  head instruction
- inst_pc  output  PC_W  PC of head instruction
- count  output  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset: fetch_pc=startpc; queue empty; count=0; inst_valid=0; mem_req=0; state=IDLE. inst and inst_pc read 0 when empty.
- FSM states:
  - IDLE: no outstanding request. If count<DEPTH and redirect=0, next cycle → REQ with mem_addr=fetch_pc.
  - REQ: mem_req=1. mem_addr and mem_req must not change until mem_ack.
    - On mem_ack: push {mem_rdata, mem_addr}; fetch_pc+=4 (mod 2^PC_W).
    - Then → REQ (next address) if a free slot remains after this cycle's push/pop, else → IDLE.
  - DROP: mem_req=1 holding the stale address. On mem_ack, discard data → IDLE.
- Request issue:
  - At most one outstanding request.
  - A request is issued only if occupancy after this cycle's push/pop is <DEPTH, so a push can never overflow.
- Queue:
  - inst_valid = (count!=0), combinational from registered state.
  - Pop when inst_valid & inst_ready; inst_ready with an empty queue is ignored.
  - Push and pop in the same cycle leave count unchanged.
  - Full (count==DEPTH): no new request.
  - Pointers wrap mod DEPTH.
- Latency: request raised 1 cycle after entering REQ conditions; instruction visible on inst 1 cycle after mem_ack. Zero-wait-state memory (ack in the same cycle as req) sustains 1 instr/cycle.
- Redirect (highest priority):
  - Queue flushed next cycle (count=0, inst_valid=0); fetch_pc=redirect_pc.
  - If in REQ without mem_ack that cycle → DROP.
  - If mem_ack coincides with redirect: data discarded, no push, → IDLE.
  - A pop coinciding with redirect is honoured: the consumer keeps that instruction.
  - Redirect while already in DROP: update fetch_pc, stay in DROP.
- Reset mid-operation: overrides everything, including an outstanding request. mem_req drops next cycle; a late mem_ack after reset is ignored (state IDLE).
- redirect_pc and startpc are not required to be word-aligned; the low 2 bits pass through unchanged.

Optional Feature:
- Macro IF_PREFETCH_PERF_EN.
- When defined, adds outputs perf_fetched (32, instructions popped) and perf_flushed (32, valid entries plus in-flight responses discarded by redirect). Both are cleared by reset and saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset with startpc=0x1000; mem_ack tied to mem_req; inst_ready=1 → inst_pc sequence 0x1000, 0x1004, 0x1008…; one instruction per cycle after 2-cycle startup.
- inst_ready=0, memory acks every request → exactly DEPTH=4 pushes (0x1000..0x100C), count=4, mem_req=0, no 5th request; raise inst_ready → fetching resumes at 0x1010.
- mem_ack delayed 3 cycles, redirect to 0x2000 in the first wait cycle → mem_addr held at old PC until ack; data discarded; next request is 0x2000; first inst_pc=0x2000.
- redirect asserted in the same cycle as mem_ack and pop with count=2 → popped instruction consumed; count=0 next cycle; acked word never appears; next mem_addr=redirect_pc.
- reset asserted while in REQ with count=3 → next cycle mem_req=0, count=0, inst_valid=0; a stray mem_ack the following cycle leaves count=0.
- With IF_PREFETCH_PERF_EN: 10 pops, then redirect with 2 queued plus 1 in flight → perf_fetched=10, perf_flushed=3.
